// File: rtl/sram_ctrl_if.sv
// Bus bundle between the CPU data-memory port, the SRAM controller and the SRAM pads.
// The slave side is the controller; the master side is the CPU plus the pad/SRAM environment.
interface sram_ctrl_if;
    logic [15:0] dm_adr;
    logic [15:0] dm_dat_o;
    logic        dm_we;
    logic        dm_req;
    logic        dm_ack;
    logic [15:0] dm_dat_i;
    logic [17:0] sram_a;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;
    logic [15:0] sram_d_o;
    logic        sram_d_oe;
    logic [15:0] sram_d_i;

    modport slave (
        input  dm_adr, dm_dat_o, dm_we, dm_req, sram_d_i,
        output dm_ack, dm_dat_i, sram_a, sram_ce_n, sram_oe_n, sram_we_n,
               sram_lb_n, sram_ub_n, sram_d_o, sram_d_oe
    );

    modport master (
        output dm_adr, dm_dat_o, dm_we, dm_req, sram_d_i,
        input  dm_ack, dm_dat_i, sram_a, sram_ce_n, sram_oe_n, sram_we_n,
               sram_lb_n, sram_ub_n, sram_d_o, sram_d_oe
    );
endinterface

// File: rtl/sram_ctrl.sv
// Async-SRAM controller: one CPU word access becomes address setup, strobe and recovery,
// with every pad-facing output registered from clk_cpu.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [1:0]  BANK        = 2'b00
) (
    input  logic       clk_cpu,
    input  logic       rst,
    sram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, STROBE, RECOVER} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       we_q;
    logic       wr_sel;
    logic       ce_n_nxt, oe_n_nxt, we_n_nxt, d_oe_nxt, ack_nxt;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        state_nxt = state;
        wr_sel    = we_q;
        ce_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        d_oe_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            IDLE:    begin
                         wr_sel = bus.dm_we;
                         if (bus.dm_req) state_nxt = ADDR;
                     end
            ADDR:    state_nxt = STROBE;
            STROBE:  if (cnt == 4'd0) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != IDLE) begin
            ce_n_nxt = 1'b0;
            d_oe_nxt = wr_sel;
        end
        if (state_nxt == STROBE) begin
            oe_n_nxt = wr_sel;
            we_n_nxt = !wr_sel;
        end
        ack_nxt = (state_nxt == RECOVER);
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            cnt           <= 4'd0;
            we_q          <= 1'b0;
            bus.sram_a    <= '0;
            bus.sram_d_o  <= '0;
            bus.sram_d_oe <= 1'b0;
            bus.sram_ce_n <= 1'b1;
            bus.sram_oe_n <= 1'b1;
            bus.sram_we_n <= 1'b1;
            bus.sram_lb_n <= 1'b1;
            bus.sram_ub_n <= 1'b1;
            bus.dm_ack    <= 1'b0;
            bus.dm_dat_i  <= '0;
        end else begin
            bus.sram_ce_n <= ce_n_nxt;
            bus.sram_lb_n <= ce_n_nxt;
            bus.sram_ub_n <= ce_n_nxt;
            bus.sram_oe_n <= oe_n_nxt;
            bus.sram_we_n <= we_n_nxt;
            bus.sram_d_oe <= d_oe_nxt;
            bus.dm_ack    <= ack_nxt;
            if (state == IDLE && bus.dm_req) begin
                bus.sram_a   <= {BANK, bus.dm_adr};
                bus.sram_d_o <= bus.dm_dat_o;
                we_q         <= bus.dm_we;
            end
            // Counter saturates at zero; it is reloaded on every ADDR.
            if (state == ADDR)                     cnt <= WAIT_LD;
            else if (state == STROBE && cnt != 0)  cnt <= cnt - 4'd1;
            if (state == STROBE && cnt == 4'd0 && !we_q)
                bus.dm_dat_i <= bus.sram_d_i;
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, random traffic against a transaction-level
// model, and hand-written sequences for back-to-back, reset abort, wait states and idle.
module tb_sram_ctrl;
    localparam int W0 = 1;

    logic clk_cpu = 1'b0;
    logic rst     = 1'b1;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;

    always #5 clk_cpu = ~clk_cpu;
    always @(posedge clk_cpu) cyc <= cyc + 1;

    sram_ctrl_if b0();
    sram_ctrl_if b1();

    sram_ctrl #(.WAIT_CYCLES(1), .BANK(2'b00)) u0 (.clk_cpu(clk_cpu), .rst(rst), .bus(b0));
    sram_ctrl #(.WAIT_CYCLES(3), .BANK(2'b10)) u1 (.clk_cpu(clk_cpu), .rst(rst), .bus(b1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // SRAM array behind u0's pads, and the model's own view of memory contents
    logic [15:0] smem    [0:65535];
    logic [15:0] ref_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) begin
        smem[i]    = dflt(16'(i));
        ref_mem[i] = dflt(16'(i));
    end

    always @(negedge clk_cpu) begin
        if (!b0.sram_ce_n && !b0.sram_we_n) smem[b0.sram_a[15:0]] <= b0.sram_d_o;
        b0.sram_d_i <= !b0.sram_oe_n ? smem[b0.sram_a[15:0]] : 16'h0000;
    end

    // Reference: k = cycles since acceptance (0 = idle); ADDR k=1, STROBE 2..2+W, RECOVER 3+W
    int          k;
    logic        m_we;
    logic [17:0] m_a;
    logic [15:0] m_d, m_dat;

    always @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            k <= 0; m_we <= 1'b0; m_a <= '0; m_d <= '0; m_dat <= '0;
        end else if (k == 0) begin
            if (b0.dm_req) begin
                k    <= 1;
                m_a  <= {2'b00, b0.dm_adr};
                m_d  <= b0.dm_dat_o;
                m_we <= b0.dm_we;
                if (b0.dm_we) ref_mem[b0.dm_adr] <= b0.dm_dat_o;
            end
        end else if (k == 3 + W0) begin
            k <= 0;
        end else begin
            if (k == 2 + W0 && !m_we) m_dat <= ref_mem[m_a[15:0]];
            k <= k + 1;
        end
    end

    logic busy_e, strb_e;
    logic [6:0] st_e;
    always @(negedge clk_cpu) begin
        if (!rst) begin
            busy_e = (k != 0);
            strb_e = (k >= 2 && k <= 2 + W0);
            st_e   = {!busy_e, !(strb_e && !m_we), !(strb_e && m_we), !busy_e, !busy_e,
                      busy_e && m_we, k == 3 + W0};
            chk("strobes", {25'd0, b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_lb_n,
                            b0.sram_ub_n, b0.sram_d_oe, b0.dm_ack}, {25'd0, st_e});
            chk("sram_a", {14'd0, b0.sram_a}, {14'd0, m_a});
            chk("dm_dat_i", {16'd0, b0.dm_dat_i}, {16'd0, m_dat});
            if (busy_e && m_we) chk("sram_d_o", {16'd0, b0.sram_d_o}, {16'd0, m_d});
            chk("contention", {31'd0, b0.sram_d_oe & ~b0.sram_oe_n}, 32'd0);
        end
    end

    task automatic txn(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                       output int lat, output logic [15:0] rd, output logic [17:0] a,
                       output int we_lo, output int oe_lo, output int doe_hi);
        @(posedge clk_cpu); #1;
        b0.dm_we = we; b0.dm_adr = adr; b0.dm_dat_o = dat; b0.dm_req = 1'b1;
        lat = -1; rd = '0; a = '0; we_lo = 0; oe_lo = 0; doe_hi = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_cpu);
            if (!b0.sram_we_n) we_lo++;
            if (!b0.sram_oe_n) oe_lo++;
            if (b0.sram_d_oe)  doe_hi++;
            if (b0.dm_ack) begin
                lat = c - 1; rd = b0.dm_dat_i; a = b0.sram_a;
                break;
            end
        end
        @(posedge clk_cpu); #1;
        b0.dm_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        tbl [9];
    int          lat, we_lo, oe_lo, doe_hi, acks, ce_hi, viol, bad;
    int          ackc [3];
    logic [15:0] rd;
    logic [17:0] a, pa;
    logic        pwe, doe_seen;

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 16'hA5C3, 16'h0000};
        tbl[1] = '{1'b0, 16'h1234, 16'h0000, 16'hA5C3};
        tbl[2] = '{1'b1, 16'h0040, 16'h0F0F, 16'hA5C3};
        tbl[3] = '{1'b0, 16'h0040, 16'h0000, 16'h0F0F};
        tbl[4] = '{1'b1, 16'h0040, 16'h1111, 16'h0F0F};
        tbl[5] = '{1'b0, 16'h0040, 16'h0000, 16'h1111};
        tbl[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
        tbl[7] = '{1'b1, 16'h0000, 16'hFFFF, 16'hA5A5};
        tbl[8] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF};

        b0.dm_req = 1'b0; b0.dm_we = 1'b0; b0.dm_adr = '0; b0.dm_dat_o = '0;
        b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_adr = '0; b1.dm_dat_o = '0;
        b1.sram_d_i = 16'h1357;

        // reset values
        @(negedge clk_cpu); #2;
        chk("rst_strobes", {25'd0, b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_lb_n,
                            b0.sram_ub_n, b0.sram_d_oe, b0.dm_ack}, 32'h7C);
        chk("rst_sram_a", {14'd0, b0.sram_a}, 32'd0);
        chk("rst_dat_i", {16'd0, b0.dm_dat_i}, 32'd0);
        chk("rst_d_o", {16'd0, b0.sram_d_o}, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            txn(tbl[i].we, tbl[i].adr, tbl[i].dat, lat, rd, a, we_lo, oe_lo, doe_hi);
            chk("tbl_latency", lat, 4);
            chk("tbl_sram_a", {14'd0, a}, {16'd0, tbl[i].adr});
            chk("tbl_dat_i", {16'd0, rd}, {16'd0, tbl[i].exp_rd});
            chk("tbl_we_lo", we_lo, tbl[i].we ? 2 : 0);
            chk("tbl_oe_lo", oe_lo, tbl[i].we ? 0 : 2);
            chk("tbl_doe_hi", doe_hi, tbl[i].we ? 4 : 0);
        end

        // random traffic over a small address window so reads hit earlier writes
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_cpu);
            txn(1'($urandom), 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom),
                lat, rd, a, we_lo, oe_lo, doe_hi);
            chk("rnd_latency", lat, 4);
        end

        // back-to-back writes with dm_req held; inputs scrambled while busy
        @(posedge clk_cpu); #1;
        b0.dm_we = 1'b1; b0.dm_adr = 16'h0200; b0.dm_dat_o = 16'hB000; b0.dm_req = 1'b1;
        acks = 0; ce_hi = 0; viol = 0; pa = b0.sram_a; pwe = 1'b1;
        for (int c = 0; c < 40 && acks < 3; c++) begin
            @(negedge clk_cpu);
            if (b0.sram_a !== pa && !pwe) viol++;
            pa = b0.sram_a; pwe = b0.sram_we_n;
            if (acks >= 1 && b0.sram_ce_n) ce_hi++;
            if (b0.dm_ack) begin
                ackc[acks] = cyc;
                acks++;
                @(posedge clk_cpu); #1;
                b0.dm_we = 1'b1;
                b0.dm_adr = 16'h0200 + 16'(acks);
                b0.dm_dat_o = 16'hB000 + 16'(acks);
                if (acks == 3) b0.dm_req = 1'b0;
            end else if (!b0.sram_ce_n) begin
                b0.dm_adr = 16'($urandom); b0.dm_dat_o = 16'($urandom); b0.dm_we = 1'($urandom);
            end
        end
        chk("b2b_acks", acks, 3);
        chk("b2b_space1", ackc[1] - ackc[0], 5);
        chk("b2b_space2", ackc[2] - ackc[1], 5);
        chk("b2b_ce_gap", ce_hi, 2);
        chk("b2b_we_before_a", viol, 0);
        txn(1'b0, 16'h0202, 16'h0000, lat, rd, a, we_lo, oe_lo, doe_hi);
        chk("b2b_readback", {16'd0, rd}, 32'h0000B002);

        // reset asserted in the middle of a write strobe
        @(posedge clk_cpu); #1;
        b0.dm_we = 1'b1; b0.dm_adr = 16'h0777; b0.dm_dat_o = 16'h7777; b0.dm_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_cpu);
            if (!b0.sram_we_n) break;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", {25'd0, b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_lb_n,
                        b0.sram_ub_n, b0.sram_d_oe, b0.dm_ack}, 32'h7C);
        b0.dm_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clk_cpu);
            if (b0.dm_ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        #2 rst = 1'b0;
        txn(1'b0, 16'h0777, 16'h0000, lat, rd, a, we_lo, oe_lo, doe_hi);
        chk("rst_after_lat", lat, 4);
        chk("rst_after_rd", {16'd0, rd}, 32'h00007777);

        // wait states and bank on the second instance
        @(posedge clk_cpu); #1;
        b1.dm_we = 1'b0; b1.dm_adr = 16'hFFFF; b1.dm_req = 1'b1;
        lat = -1; oe_lo = 0; doe_seen = 1'b0; a = '0; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_cpu);
            if (!b1.sram_oe_n) oe_lo++;
            if (b1.sram_d_oe)  doe_seen = 1'b1;
            if (!b1.sram_ce_n) a = b1.sram_a;
            if (b1.dm_ack) begin
                lat = c - 1; rd = b1.dm_dat_i;
                break;
            end
        end
        @(posedge clk_cpu); #1;
        b1.dm_req = 1'b0;
        chk("ws_latency", lat, 6);
        chk("ws_oe_lo", oe_lo, 4);
        chk("ws_d_oe", {31'd0, doe_seen}, 32'd0);
        chk("ws_sram_a", {14'd0, a}, 32'h0002FFFF);
        chk("ws_dat_i", {16'd0, rd}, 32'h00001357);

        // idle
        bad = 0;
        repeat (100) begin
            @(negedge clk_cpu);
            if (b0.dm_ack || !b0.sram_ce_n || !b0.sram_oe_n || !b0.sram_we_n ||
                !b0.sram_lb_n || !b0.sram_ub_n || b0.sram_d_oe) bad++;
        end
        chk("idle_quiet", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Asynchronous-SRAM controller between the CPU data-memory port (`dm_*` request/acknowledge bus) and the board's external 256K×16 SRAM. It converts one CPU word transaction into a fixed-timing SRAM cycle of address setup, strobe and recovery. It returns read data with a single-cycle acknowledge. The pad-level tristate lives outside the block: it drives `sram_d_o`/`sram_d_oe` into a bidirectional pad cell and samples `sram_d_i` from that pad cell.

## Interface
- `WAIT_CYCLES`, default 1: extra strobe cycles beyond the first; legal range 0..15.
- `BANK`, default 2'b00: upper two SRAM address bits prepended to the 16-bit CPU word address.

Ports:
- `clk_cpu` input 1: CPU clock; the only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `dm_adr` input 16: CPU word address.
- `dm_dat_o` input 16: CPU write data.
- `dm_we` input 1: 1 = write, 0 = read; qualified by `dm_req`.
- `dm_req` input 1: request level, held until `dm_ack`.
- `dm_ack` output 1: one-cycle completion pulse.
- `dm_dat_i` output 16: read data, valid from `dm_ack` until the next read completes.
- `sram_a` output 18: SRAM address.
- `sram_ce_n` output 1: chip enable, active-low.
- `sram_oe_n` output 1: output enable, active-low.
- `sram_we_n` output 1: write enable, active-low.
- `sram_lb_n` output 1: lower byte enable, active-low.
- `sram_ub_n` output 1: upper byte enable, active-low.
- `sram_d_o` output 16: data to the pad.
- `sram_d_oe` output 1: pad output enable, active-high.
- `sram_d_i` input 16: data from the pad.

## Operation
- States: IDLE, ADDR, STROBE, RECOVER.
- IDLE:
  - All strobes are inactive: `ce_n`, `oe_n`, `we_n`, `lb_n`, `ub_n` = 1, `sram_d_oe` = 0.
  - `dm_req`=1 at a clock edge latches `sram_a` = {BANK, dm_adr}, `dm_we` and `dm_dat_o` into registers, then → ADDR.
- ADDR (1 cycle):
  - `ce_n`, `lb_n`, `ub_n` = 0.
  - Write: `sram_d_o` = latched data and `sram_d_oe` = 1.
  - `oe_n` and `we_n` stay 1.
  - → STROBE, with the wait counter loaded to WAIT_CYCLES.
- STROBE (WAIT_CYCLES+1 cycles):
  - Read: `oe_n` = 0. Write: `we_n` = 0.
  - The counter decrements each cycle. At count 0, → RECOVER.
  - Read: on that same edge `dm_dat_i` <= `sram_d_i`.
- RECOVER (1 cycle):
  - `oe_n` and `we_n` return to 1.
  - `ce_n`, `lb_n`, `ub_n` stay 0; `sram_a` is held.
  - Write: `sram_d_oe` stays 1, giving data hold past the `we_n` rising edge.
  - `dm_ack` = 1. → IDLE.
- `sram_a` and the latched write data are stable from ADDR through RECOVER; they hold their last value in IDLE.
- `dm_dat_i` changes only at the end of a read STROBE. Writes never alter it.
- Requests are not accepted in ADDR, STROBE or RECOVER. Changes to `dm_adr`, `dm_we` or `dm_dat_o` during those states are ignored.
- Back-to-back: `dm_req` still high in the IDLE cycle following `dm_ack` starts a new transaction.
- `sram_d_oe` is never 1 while `oe_n` is 0, so there is no bus contention.

## Timing
- All outputs are registered from `clk_cpu`.
- Reset values:
  - state IDLE, `dm_ack`=0, `dm_dat_i`=0, `sram_a`=0, `sram_d_o`=0, `sram_d_oe`=0.
  - All active-low strobes = 1.
- Reset asserted mid-transaction forces these values immediately, asynchronously. The transaction is dropped and no `dm_ack` is issued.
- Latency, with `dm_req` sampled high at the end of IDLE cycle n:
  - ADDR in cycle n+1.
  - STROBE in cycles n+2 .. n+2+WAIT_CYCLES.
  - RECOVER with `dm_ack`=1 in cycle n+3+WAIT_CYCLES.
- Minimum transaction spacing is WAIT_CYCLES+4 cycles, including the IDLE acceptance cycle. This is 5 cycles for the default.
- `dm_ack` is high for exactly one cycle per accepted request.
- The counter is 4 bits wide and never wraps: it is loaded in ADDR and stops at 0.

## Test plan
- Write then read, default params: write 16'hA5C3 to `dm_adr` 16'h1234.
  - Required: `sram_a` = 18'h01234; `we_n` low for 2 cycles; `sram_d_oe` high for 4 cycles; `dm_ack` pulses 4 cycles after acceptance.
  - Read back with the SRAM model returning 16'hA5C3 → `dm_dat_i` = 16'hA5C3 in the `dm_ack` cycle.
- Wait states, WAIT_CYCLES=3, BANK=2'b10: read `dm_adr` 16'hFFFF.
  - Required: `sram_a` = 18'h2FFFF; `oe_n` low for exactly 4 cycles; `dm_ack` 6 cycles after acceptance; `sram_d_oe` stays 0 throughout.
- Back-to-back: `dm_req` held high across 3 writes.
  - Required: 3 `dm_ack` pulses spaced 5 cycles apart; `we_n` returns high before `sram_a` changes; `ce_n` high for exactly one cycle between transactions.
- Reset mid-strobe: assert `rst` during a write STROBE.
  - Required: `we_n`, `ce_n` = 1 and `sram_d_oe` = 0 in the same cycle; no `dm_ack`; after release, the next request completes normally.
- Read data hold: read returns 16'h0F0F, then write 16'h1111.
  - Required: `dm_dat_i` stays 16'h0F0F through the write and its `dm_ack`.
- Idle: `dm_req`=0 for 100 cycles.
  - Required: all strobes 1, `sram_d_oe`=0, `dm_ack` never asserted.
